// File: rtl/decode_issue_reg_way1_if.sv
// -----------------------------------------------------------------------------
// decode_issue_reg_way1_if
//   Valid/ready handshake plus the decoded way-1 instruction bundle.
//   master : drives valid and the bundle fields, receives ready
//   slave  : receives valid and the bundle fields, drives ready
//   Parameter XLEN : operand / immediate width
// -----------------------------------------------------------------------------
interface decode_issue_reg_way1_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic [31:0]     inst_addr;
  logic [1:0]      pid;
  logic [4:0]      rd_addr;
  logic            rd_write_enable;
  logic [XLEN-1:0] rs1_read_data;
  logic [XLEN-1:0] rs2_read_data;
  logic [XLEN-1:0] imm;
  logic [6:0]      op_code;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [5:0]      shamt;

  modport master (
    output valid, inst_addr, pid, rd_addr, rd_write_enable,
           rs1_read_data, rs2_read_data, imm, op_code, funct3, funct7, shamt,
    input  ready
  );

  modport slave (
    input  valid, inst_addr, pid, rd_addr, rd_write_enable,
           rs1_read_data, rs2_read_data, imm, op_code, funct3, funct7, shamt,
    output ready
  );
endinterface

// File: rtl/decode_issue_reg_way1.sv
// -----------------------------------------------------------------------------
// decode_issue_reg_way1
//   Two-entry elastic pipeline register between the way-1 decoder and the
//   way-1 execute stage. Bundles are held in a 2-deep FIFO; the head entry is
//   presented to execute. valid/ready toward both neighbours come from flops,
//   so there is no combinational path from ready in to ready out. A jump
//   redirect discards every held bundle and any bundle offered that cycle.
//
//   clk        : core clock, rising edge
//   reset_n    : asynchronous active-low reset
//   jumpFlag_i : redirect, flushes the buffer
//   up         : slave side, bundle from the decoder
//   dn         : master side, head bundle to execute
//   count_o    : occupancy 0..2
// -----------------------------------------------------------------------------
module decode_issue_reg_way1 #(
  parameter int XLEN = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         jumpFlag_i,
  decode_issue_reg_way1_if.slave       up,
  decode_issue_reg_way1_if.master      dn,
  output logic [1:0]                   count_o
);

  typedef struct packed {
    logic [31:0]     inst_addr;
    logic [1:0]      pid;
    logic [4:0]      rd_addr;
    logic            rd_write_enable;
    logic [XLEN-1:0] rs1_read_data;
    logic [XLEN-1:0] rs2_read_data;
    logic [XLEN-1:0] imm;
    logic [6:0]      op_code;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      shamt;
  } bundle_t;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e  state, state_nx;
  logic    wp, rp;
  logic    valid_q, ready_q;
  bundle_t mem [2];
  bundle_t in_bundle;
  bundle_t head;
  logic    push, pop;

  assign in_bundle = '{
    inst_addr:       up.inst_addr,
    pid:             up.pid,
    rd_addr:         up.rd_addr,
    rd_write_enable: up.rd_write_enable,
    rs1_read_data:   up.rs1_read_data,
    rs2_read_data:   up.rs2_read_data,
    imm:             up.imm,
    op_code:         up.op_code,
    funct3:          up.funct3,
    funct7:          up.funct7,
    shamt:           up.shamt
  };

  // A handshake in a flush cycle is neither a push nor a pop.
  assign push = up.valid & ready_q & ~jumpFlag_i;
  assign pop  = valid_q & dn.ready & ~jumpFlag_i;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (jumpFlag_i) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nx = ONE;
        ONE: begin
          if (push && !pop)      state_nx = FULL;
          else if (pop && !push) state_nx = EMPTY;
        end
        FULL:    if (pop) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      wp      <= 1'b0;
      rp      <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      // NOTE: the storage is reset as well so the bundle outputs read zero
      // after reset; it is only two entries, so this costs almost nothing.
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else begin
      state   <= state_nx;
      valid_q <= (state_nx != EMPTY);
      ready_q <= (state_nx != FULL);
      if (jumpFlag_i) begin
        wp <= 1'b0;
        rp <= 1'b0;
      end else begin
        if (push) begin
          mem[wp] <= in_bundle;
          wp      <= ~wp;
        end
        if (pop) begin
          rp <= ~rp;
        end
      end
    end
  end

  assign head     = mem[rp];
  assign up.ready = ready_q;
  assign count_o  = state;

  assign dn.valid           = valid_q;
  assign dn.inst_addr       = head.inst_addr;
  assign dn.pid             = head.pid;
  assign dn.rd_addr         = head.rd_addr;
  assign dn.rd_write_enable = head.rd_write_enable;
  assign dn.rs1_read_data   = head.rs1_read_data;
  assign dn.rs2_read_data   = head.rs2_read_data;
  assign dn.imm             = head.imm;
  assign dn.op_code         = head.op_code;
  assign dn.funct3          = head.funct3;
  assign dn.funct7          = head.funct7;
  assign dn.shamt           = head.shamt;

endmodule

// File: tb/tb_decode_issue_reg_way1.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_reg_way1
//   Self-checking bench. A queue of bundles is the reference: a bundle is
//   accepted when offered while the queue holds fewer than two, the queue
//   front leaves when execute is ready, and a jump empties the queue.
// -----------------------------------------------------------------------------
module tb_decode_issue_reg_way1;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [31:0]     inst_addr;
    logic [1:0]      pid;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [6:0]      op_code;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      shamt;
  } bundle_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       jump = 1'b0;
  logic [1:0] count;

  decode_issue_reg_way1_if #(.XLEN(XLEN)) up_if ();
  decode_issue_reg_way1_if #(.XLEN(XLEN)) dn_if ();

  decode_issue_reg_way1 #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .jumpFlag_i (jump),
    .up         (up_if),
    .dn         (dn_if),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  int      vectors = 0;
  int      miscompares = 0;
  bundle_t q[$];

  function automatic bundle_t rand_bundle(input logic [31:0] addr);
    bundle_t b;
    b.inst_addr = addr;
    b.pid       = 2'($urandom);
    b.rd_addr   = 5'($urandom);
    b.rd_we     = 1'($urandom);
    b.rs1       = {$urandom, $urandom};
    b.rs2       = {$urandom, $urandom};
    b.imm       = {$urandom, $urandom};
    b.op_code   = 7'($urandom);
    b.funct3    = 3'($urandom);
    b.funct7    = 7'($urandom);
    b.shamt     = 6'($urandom);
    return b;
  endfunction

  task automatic drive(input logic v, input bundle_t b);
    up_if.valid           = v;
    up_if.inst_addr       = b.inst_addr;
    up_if.pid             = b.pid;
    up_if.rd_addr         = b.rd_addr;
    up_if.rd_write_enable = b.rd_we;
    up_if.rs1_read_data   = b.rs1;
    up_if.rs2_read_data   = b.rs2;
    up_if.imm             = b.imm;
    up_if.op_code         = b.op_code;
    up_if.funct3          = b.funct3;
    up_if.funct7          = b.funct7;
    up_if.shamt           = b.shamt;
  endtask

  function automatic bundle_t offered();
    return '{up_if.inst_addr, up_if.pid, up_if.rd_addr, up_if.rd_write_enable,
             up_if.rs1_read_data, up_if.rs2_read_data, up_if.imm,
             up_if.op_code, up_if.funct3, up_if.funct7, up_if.shamt};
  endfunction

  function automatic bundle_t dut_head();
    return '{dn_if.inst_addr, dn_if.pid, dn_if.rd_addr, dn_if.rd_write_enable,
             dn_if.rs1_read_data, dn_if.rs2_read_data, dn_if.imm,
             dn_if.op_code, dn_if.funct3, dn_if.funct7, dn_if.shamt};
  endfunction

  // One clock: update the reference from the inputs seen at the edge, then
  // move 1 time unit past the edge where outputs are sampled and inputs driven.
  task automatic step();
    bit accept, leave;
    @(posedge clk);
    accept = up_if.valid && (q.size() < 2) && !jump;
    leave  = (q.size() > 0) && dn_if.ready && !jump;
    if (jump) begin
      q.delete();
    end else begin
      if (leave)  void'(q.pop_front());
      if (accept) q.push_back(offered());
    end
    #1;
  endtask

  task automatic test_reset();
    bundle_t b;
    drive(1'b0, '0);
    dn_if.ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got valid=%b ready=%b count=%0d expected valid=0 ready=1 count=0",
               dn_if.valid, up_if.ready, count);
    end
    vectors++;
    if (dut_head() !== '0) begin
      miscompares++;
      $display("FAIL reset_bundle: got %h expected 0", dut_head());
    end
    reset_n = 1'b1;
    b = rand_bundle(32'h8000_0000);
    drive(1'b1, b);
    dn_if.ready = 1'b1;
    step();
    vectors++;
    if (dn_if.valid !== 1'b1 || dn_if.inst_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL first_push: got valid=%b addr=%h expected valid=1 addr=80000000",
               dn_if.valid, dn_if.inst_addr);
    end
    drive(1'b0, '0);
    step();
    vectors++;
    if (count !== 2'd0 || dn_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL first_drain: got count=%0d valid=%b expected count=0 valid=0", count, dn_if.valid);
    end
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, rand_bundle(32'h8000_0000 + 32'(4 * k)));
      step();
      vectors++;
      if (dn_if.valid !== 1'b1 || dut_head() !== q[0] || dn_if.inst_addr !== 32'h8000_0000 + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL stream_head%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                 k, dn_if.valid, dn_if.inst_addr, 32'h8000_0000 + 32'(4 * k));
      end
      vectors++;
      if (count !== 2'd1 || up_if.ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_occ%0d: got count=%0d ready=%b expected count=1 ready=1", k, count, up_if.ready);
      end
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_backpressure();
    bundle_t a, b, c;
    a = rand_bundle(32'h1000);
    b = rand_bundle(32'h1004);
    c = rand_bundle(32'h1008);
    dn_if.ready = 1'b0;
    drive(1'b1, a); step();
    drive(1'b1, b); step();
    vectors++;
    if (count !== 2'd2 || up_if.ready !== 1'b0 || dut_head() !== a) begin
      miscompares++;
      $display("FAIL bp_full: got count=%0d ready=%b addr=%h expected count=2 ready=0 addr=%h",
               count, up_if.ready, dn_if.inst_addr, a.inst_addr);
    end
    drive(1'b1, c); step();
    vectors++;
    if (count !== 2'd2 || dut_head() !== a) begin
      miscompares++;
      $display("FAIL bp_hold: got count=%0d addr=%h expected count=2 addr=%h", count, dn_if.inst_addr, a.inst_addr);
    end
    dn_if.ready = 1'b1;
    step();
    vectors++;
    if (count !== 2'd1 || up_if.ready !== 1'b1 || dut_head() !== b) begin
      miscompares++;
      $display("FAIL bp_pop_a: got count=%0d ready=%b addr=%h expected count=1 ready=1 addr=%h",
               count, up_if.ready, dn_if.inst_addr, b.inst_addr);
    end
    step();
    vectors++;
    if (count !== 2'd1 || dut_head() !== c) begin
      miscompares++;
      $display("FAIL bp_c_head: got count=%0d addr=%h expected count=1 addr=%h", count, dn_if.inst_addr, c.inst_addr);
    end
    drive(1'b0, '0);
    step();
    vectors++;
    if (count !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_drain: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_simultaneous();
    bundle_t a, b;
    a = rand_bundle(32'h2000);
    b = rand_bundle(32'h2004);
    dn_if.ready = 1'b0;
    drive(1'b1, a); step();
    dn_if.ready = 1'b1;
    drive(1'b1, b); step();
    vectors++;
    if (count !== 2'd1 || dut_head() !== b) begin
      miscompares++;
      $display("FAIL simul: got count=%0d addr=%h expected count=1 addr=%h", count, dn_if.inst_addr, b.inst_addr);
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_flush();
    bundle_t a, b, c, d;
    a = rand_bundle(32'h3000);
    b = rand_bundle(32'h3004);
    c = rand_bundle(32'h3008);
    d = rand_bundle(32'h300c);
    d.pid = ~c.pid;
    dn_if.ready = 1'b0;
    drive(1'b1, a); step();
    drive(1'b1, b); step();
    drive(1'b1, c);
    dn_if.ready = 1'b1;
    jump = 1'b1;
    step();
    jump = 1'b0;
    vectors++;
    if (dn_if.valid !== 1'b0 || count !== 2'd0 || up_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: got valid=%b count=%0d ready=%b expected valid=0 count=0 ready=1",
               dn_if.valid, count, up_if.ready);
    end
    drive(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (dn_if.valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_idle%0d: got valid=%b expected 0", i, dn_if.valid);
      end
    end
    drive(1'b1, d);
    step();
    vectors++;
    if (dn_if.valid !== 1'b1 || dn_if.pid !== d.pid || dut_head() !== d) begin
      miscompares++;
      $display("FAIL flush_next: got valid=%b pid=%0d addr=%h expected valid=1 pid=%0d addr=%h",
               dn_if.valid, dn_if.pid, dn_if.inst_addr, d.pid, d.inst_addr);
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_bundle($urandom));
      dn_if.ready = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      jump = ($urandom_range(0, 24) == 0);
      step();
      vectors++;
      if (dn_if.valid !== (q.size() != 0) || up_if.ready !== (q.size() < 2) || count !== 2'(q.size())) begin
        miscompares++;
        $display("FAIL rand_flags%0d: got valid=%b ready=%b count=%0d expected count=%0d",
                 i, dn_if.valid, up_if.ready, count, q.size());
      end
      if (q.size() != 0) begin
        vectors++;
        if (dut_head() !== q[0]) begin
          miscompares++;
          $display("FAIL rand_head%0d: got %h expected %h", i, dut_head(), q[0]);
        end
      end
    end
    jump = 1'b0;
    drive(1'b0, '0);
    dn_if.ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    dn_if.ready = 1'b0;
    drive(1'b1, rand_bundle(32'h4000)); step();
    drive(1'b1, rand_bundle(32'h4004)); step();
    drive(1'b0, '0);
    vectors++;
    if (count !== 2'd2) begin
      miscompares++;
      $display("FAIL async_pre: got count=%0d expected 2", count);
    end
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    vectors++;
    if (dn_if.valid !== 1'b0 || count !== 2'd0 || up_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b count=%0d ready=%b expected valid=0 count=0 ready=1",
               dn_if.valid, count, up_if.ready);
    end
    #2 reset_n = 1'b1;
    dn_if.ready = 1'b1;
    drive(1'b1, rand_bundle(32'h5000));
    step();
    vectors++;
    if (dn_if.valid !== 1'b1 || dut_head() !== q[0]) begin
      miscompares++;
      $display("FAIL async_after: got valid=%b addr=%h expected valid=1 addr=00005000",
               dn_if.valid, dn_if.inst_addr);
    end
    drive(1'b0, '0);
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
